// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the two-requester ALU arbiter:
//     - ALU control code constants (AND, OR, ADD, SUB, PASSB)
//     - FSM state encoding used by alu_arbiter (IDLE / EXEC / RESP)
//     - is_legal_op(): true for the five supported control codes; only used
//       when the ALU_OPCHECK_EN build macro is defined.
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] ctrl);
        logic legal;
        legal = 1'b0;
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin grant logic, purely combinational.
//   Ports:
//     valid_i [1:0] : request lines of requester 0 and 1
//     ptr_i         : requester that has priority when both request
//     grant_o [1:0] : one-hot grant (all zero when nothing requests)
//   The pointer is owned by the caller, which moves it away from the
//   requester it just served.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE, its operands are registered and held on alu_* for
//   EXEC_CYCLES cycles, then the ALU result is captured and offered on the
//   response port until it is taken.
//
//   Build macro: ALU_OPCHECK_EN
//     defined   : unsupported control codes bypass EXEC and produce an error
//                 response (rsp_err=1, rsp_w=0, rsp_zero=1) on the next cycle,
//                 leaving alu_* untouched.
//     undefined : every code is executed; rsp_err is constant 0.
//
//   Handshake rule (both request ports and the response port): a transfer
//   happens on the rising CLK edge where valid and ready are both high;
//   valid may drop at any time before that edge without side effects, and
//   ready depends on the FSM state and the current valids only.
//
//   Ports:
//     CLK, Reset               : clock, synchronous active-high reset
//     reqN_valid / reqN_ready  : requester N handshake (N = 0, 1)
//     reqN_a, reqN_b, reqN_ctrl: requester N operands and ALU control code
//     alu_a, alu_b, alu_ctrl   : registered operands driven to the ALU
//     alu_w, alu_zero          : ALU result and zero flag
//     rsp_valid / rsp_ready    : response handshake
//     rsp_id                   : requester that owns the response
//     rsp_w, rsp_zero, rsp_err : captured result, zero flag, illegal-op flag
//     busy                     : high whenever the FSM is not IDLE
//     dbg_state                : current FSM state encoding (debug)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_w,
    output logic             rsp_zero,
    output logic             rsp_err,

    output logic             busy,
    output logic [1:0]       dbg_state
);

    // The counter is loaded with EXEC_CYCLES-1 and the result is captured on
    // the edge where it reads zero, so EXEC spans exactly EXEC_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_w_q, rsp_w_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic [1:0]       grant;
    logic             accept;
    logic             sel_req1;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_ctrl;
    logic             op_illegal;

    rr_arbiter2 u_rr (
        .valid_i (Reset ? 2'b00 : {req1_valid, req0_valid}),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Grant is one-hot, so the winner's operands can be muxed by grant[1].
    assign sel_req1 = grant[1];
    assign sel_a    = sel_req1 ? req1_a    : req0_a;
    assign sel_b    = sel_req1 ? req1_b    : req0_b;
    assign sel_ctrl = sel_req1 ? req1_ctrl : req0_ctrl;
    assign accept   = (state_q == ST_IDLE) && (grant != 2'b00);

`ifdef ALU_OPCHECK_EN
    assign op_illegal = !is_legal_op(sel_ctrl);
`else
    // Without the op check every code executes, so the error flag register
    // only ever loads 0 and rsp_err is a constant 0.
    assign op_illegal = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        id_d       = id_q;
        rsp_w_d    = rsp_w_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (accept) begin
                    id_d = sel_req1;
                    if (op_illegal) begin
                        // Error response is formed immediately; the ALU
                        // never sees the rejected operands.
                        rsp_w_d    = '0;
                        rsp_zero_d = 1'b1;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_ctrl_d = sel_ctrl;
                        cnt_d      = CNT_LOAD;
                        state_d    = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_w_d    = alu_w;
                    rsp_zero_d = alu_zero;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    // Priority goes to the requester that was not just served.
                    ptr_d   = ~id_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= 4'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= ALU_AND;
            id_q       <= 1'b0;
            rsp_w_q    <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            id_q       <= id_d;
            rsp_w_q    <= rsp_w_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_w     = rsp_w_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Two instances share clock and reset:
//   dut (EXEC_CYCLES=1) and dut3 (EXEC_CYCLES=3). Each has its own
//   behavioural ALU computed from its alu_* outputs. Outputs are sampled
//   1 time unit after the rising edge; inputs change at the same point.
//   Build macro ALU_OPCHECK_EN selects the expected illegal-op behaviour.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 64;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    // ---------------- dut signals (EXEC_CYCLES = 1) ----------------
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_w;
    logic [3:0]   alu_ctrl;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [W-1:0] rsp_w;
    logic [1:0]   dbg_state;

    // ---------------- dut3 signals (EXEC_CYCLES = 3) ----------------
    logic         d3_req0_valid, d3_req0_ready, d3_req1_valid, d3_req1_ready;
    logic [W-1:0] d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b;
    logic [3:0]   d3_req0_ctrl, d3_req1_ctrl;
    logic [W-1:0] d3_alu_a, d3_alu_b, d3_alu_w;
    logic [3:0]   d3_alu_ctrl;
    logic         d3_alu_zero;
    logic         d3_rsp_valid, d3_rsp_ready, d3_rsp_id, d3_rsp_zero, d3_rsp_err, d3_busy;
    logic [W-1:0] d3_rsp_w;
    logic [1:0]   d3_dbg_state;

    int checks = 0;
    int errors = 0;

    // Behavioural shared ALU.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] c);
        logic [W-1:0] r;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_w       = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero    = (alu_w == '0);
    assign d3_alu_w    = alu_fn(d3_alu_a, d3_alu_b, d3_alu_ctrl);
    assign d3_alu_zero = (d3_alu_w == '0);

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(1)) dut (
        .CLK(CLK), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_w(alu_w), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_w(rsp_w), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(3)) dut3 (
        .CLK(CLK), .Reset(Reset),
        .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready),
        .req0_a(d3_req0_a), .req0_b(d3_req0_b), .req0_ctrl(d3_req0_ctrl),
        .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready),
        .req1_a(d3_req1_a), .req1_b(d3_req1_b), .req1_ctrl(d3_req1_ctrl),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_ctrl(d3_alu_ctrl),
        .alu_w(d3_alu_w), .alu_zero(d3_alu_zero),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
        .rsp_w(d3_rsp_w), .rsp_zero(d3_rsp_zero), .rsp_err(d3_rsp_err),
        .busy(d3_busy), .dbg_state(d3_dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = 4'd0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = 4'd0;
        rsp_ready  = 1'b1;
        d3_req0_valid = 1'b0; d3_req0_a = '0; d3_req0_b = '0; d3_req0_ctrl = 4'd0;
        d3_req1_valid = 1'b0; d3_req1_a = '0; d3_req1_b = '0; d3_req1_ctrl = 4'd0;
        d3_rsp_ready  = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    // Checks every dut output against its reset value.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"},     alu_a,     '0);
        check({tag, "_alu_b"},     alu_b,     '0);
        check({tag, "_alu_ctrl"},  W'(alu_ctrl), '0);
        check({tag, "_rsp_valid"}, W'(rsp_valid), '0);
        check({tag, "_rsp_id"},    W'(rsp_id),    '0);
        check({tag, "_rsp_w"},     rsp_w,     '0);
        check({tag, "_rsp_zero"},  W'(rsp_zero),  '0);
        check({tag, "_rsp_err"},   W'(rsp_err),   '0);
        check({tag, "_busy"},      W'(busy),      '0);
        check({tag, "_state"},     W'(dbg_state), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] exp_alu_a;

    initial begin
        Reset = 1'b1;
        idle_inputs();

        // ---- reset state ----
        apply_reset();
        check_reset_outputs("rst");
        check("rst_d3_rsp_valid", W'(d3_rsp_valid), '0);

        // ---- single req0 ADD 5+7, result two cycles after handshake cycle ----
        req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd7; req0_ctrl = 4'b0010;
        #1;
        check("add_r0_ready", W'(req0_ready), 1);
        check("add_r1_ready", W'(req1_ready), 0);
        step();                                   // handshake edge
        req0_valid = 1'b0; req0_a = 64'd99;       // operands must come from registers
        check("add_exec_busy",  W'(busy), 1);
        check("add_exec_valid", W'(rsp_valid), 0);
        check("add_exec_alu_a", alu_a, 64'd5);
        check("add_exec_r0rdy", W'(req0_ready), 0);
        step();
        check("add_rsp_valid", W'(rsp_valid), 1);
        check("add_rsp_w",     rsp_w, 64'd12);
        check("add_rsp_zero",  W'(rsp_zero), 0);
        check("add_rsp_id",    W'(rsp_id), 0);
        check("add_rsp_err",   W'(rsp_err), 0);
        step();                                   // rsp_ready=1 takes the response
        check("add_idle_valid", W'(rsp_valid), 0);
        check("add_idle_busy",  W'(busy), 0);

        // ---- round robin: both valid every cycle, grants 0,1,0,1 ----
        apply_reset();
        req0_valid = 1'b1; req0_a = 64'd100; req0_b = 64'd23; req0_ctrl = 4'b0010; // 123
        req1_valid = 1'b1; req1_a = 64'd50;  req1_b = 64'd8;  req1_ctrl = 4'b0110; // 42
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr%0d_r0_ready", i), W'(req0_ready), W'((i % 2) == 0));
            check($sformatf("rr%0d_r1_ready", i), W'(req1_ready), W'((i % 2) == 1));
            step();
            step();
            check($sformatf("rr%0d_valid", i), W'(rsp_valid), 1);
            check($sformatf("rr%0d_id", i),    W'(rsp_id), W'(i % 2));
            check($sformatf("rr%0d_w", i),     rsp_w, ((i % 2) == 0) ? 64'd123 : 64'd42);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---- req1 SUB 9-9 with rsp_ready low for 5 cycles ----
        apply_reset();
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd9; req1_b = 64'd9; req1_ctrl = 4'b0110;
        #1;
        check("sub_r1_ready", W'(req1_ready), 1);
        check("sub_r0_ready", W'(req0_ready), 0);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1; req0_ctrl = 4'b0010;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("sub_hold%0d_valid", k), W'(rsp_valid), 1);
            check($sformatf("sub_hold%0d_w", k),     rsp_w, 64'd0);
            check($sformatf("sub_hold%0d_zero", k),  W'(rsp_zero), 1);
            check($sformatf("sub_hold%0d_id", k),    W'(rsp_id), 1);
            check($sformatf("sub_hold%0d_rdy", k),   W'({req0_ready, req1_ready}), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        step();                                   // response taken
        check("sub_idle_busy", W'(busy), 0);
        check("sub_ptr_r0_rdy", W'(req0_ready), 1); // pointer moved away from 1
        req0_valid = 1'b0;

        // ---- priority after serving 0: both valid -> 1 wins ----
        apply_reset();
        req0_valid = 1'b1; req0_a = 64'h3; req0_b = 64'h5; req0_ctrl = 4'b0001;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        check("or_rsp_w", rsp_w, 64'h7);
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 64'h0; req1_b = 64'hABCD; req1_ctrl = 4'b0111;
        #1;
        check("ptr_r1_wins", W'(req1_ready), 1);
        check("ptr_r0_waits", W'(req0_ready), 0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        check("passb_rsp_w",  rsp_w, 64'hABCD);
        check("passb_rsp_id", W'(rsp_id), 1);
        step();

        // ---- EXEC_CYCLES = 3: AND 0xF0 & 0x3C ----
        apply_reset();
        d3_req0_valid = 1'b1; d3_req0_a = 64'hF0; d3_req0_b = 64'h3C; d3_req0_ctrl = 4'b0000;
        #1;
        check("d3_r0_ready", W'(d3_req0_ready), 1);
        step();
        d3_req0_valid = 1'b0; d3_req0_a = 64'hFF; d3_req0_b = 64'hFF; d3_req0_ctrl = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d3_exec%0d_alu_a", k),  d3_alu_a, 64'hF0);
            check($sformatf("d3_exec%0d_alu_b", k),  d3_alu_b, 64'h3C);
            check($sformatf("d3_exec%0d_ctrl", k),   W'(d3_alu_ctrl), 0);
            check($sformatf("d3_exec%0d_valid", k),  W'(d3_rsp_valid), 0);
            step();
        end
        check("d3_rsp_valid", W'(d3_rsp_valid), 1);
        check("d3_rsp_w",     d3_rsp_w, 64'h30);
        check("d3_rsp_zero",  W'(d3_rsp_zero), 0);
        step();
        check("d3_idle_busy", W'(d3_busy), 0);

        // ---- reset pulsed during EXEC aborts the operation ----
        apply_reset();
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_ctrl = 4'b0010;
        #1;
        step();
        req0_valid = 1'b0;
        check("abort_in_exec", W'(dbg_state), 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_reset_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("abort_quiet%0d", k), W'(rsp_valid), 0);
        end

        // ---- illegal control code 4'b1111 ----
        apply_reset();
        req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4; req0_ctrl = 4'b1111;
        #1;
        step();
        req0_valid = 1'b0;
`ifdef ALU_OPCHECK_EN
        check("ill_rsp_valid", W'(rsp_valid), 1);
        check("ill_rsp_err",   W'(rsp_err), 1);
        check("ill_rsp_w",     rsp_w, 64'd0);
        check("ill_rsp_zero",  W'(rsp_zero), 1);
        check("ill_alu_a",     alu_a, 64'd0);
        check("ill_alu_ctrl",  W'(alu_ctrl), 0);
        exp_alu_a = 64'd0;
`else
        check("ill_exec_valid", W'(rsp_valid), 0);
        check("ill_exec_ctrl",  W'(alu_ctrl), 64'hF);
        check("ill_exec_alu_a", alu_a, 64'd3);
        step();
        check("ill_rsp_valid", W'(rsp_valid), 1);
        check("ill_rsp_err",   W'(rsp_err), 0);
        check("ill_rsp_w",     rsp_w, 64'd0);
        check("ill_rsp_zero",  W'(rsp_zero), 1);
        exp_alu_a = 64'd3;
`endif
        step();
        check("ill_idle_busy", W'(busy), 0);

        // ---- request withdrawn before handshake changes nothing ----
        req1_valid = 1'b1; req1_a = 64'd77; req1_b = 64'd1; req1_ctrl = 4'b0010;
        #1;
        check("wd_r1_ready", W'(req1_ready), 1);
        req1_valid = 1'b0;
        step();
        check("wd_busy",  W'(busy), 0);
        check("wd_alu_a", alu_a, exp_alu_a);
        step();
        check("wd_valid", W'(rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
